div64_seq: RTL



---
 rtl/div_pkg.sv | 23 ++
 rtl/adder64b.sv | 20 ++
 rtl/div64_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, op encoding and FSM state type for div64_seq
package div_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Two's-complement negation used for sign capture and sign fix-up.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/adder64b.sv
// rtl/adder64b.sv - 64-bit adder/subtractor; c_o is carry out (no-borrow flag when sub=1)
module adder64b (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        sub,
  output logic [63:0] s,
  output logic        c_o
);

  logic [64:0] sum;

  // a + b, or a + ~b + 1 when subtracting
  always_comb begin
    sum = {1'b0, a} + {1'b0, b ^ {64{sub}}} + {64'd0, sub};
  end

  assign s   = sum[63:0];
  assign c_o = sum[64];

endmodule

// File: rtl/div64_seq.sv
// rtl/div64_seq.sv - iterative RV64M DIV/DIVU/REM/REMU divider; DIV_EARLY_OUT_EN enables a divide-by-zero bypass
module div64_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import div_pkg::div_state_t;
  import div_pkg::ST_IDLE;
  import div_pkg::ST_RUN;
  import div_pkg::ST_FIX;
  import div_pkg::ST_DONE;
  import div_pkg::DIV_OP_DIV;
  import div_pkg::DIV_OP_REM;
  import div_pkg::DIV_OP_REMU;
  import div_pkg::negate;

  div_state_t      state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] r;
  logic            neg_q;
  logic            neg_r;
  logic [5:0]      cnt;

  logic            signed_op;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] diff;
  logic            c_o;
  logic            qbit;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            is_rem;
  logic [XLEN-1:0] fix_result;

  // Operand magnitudes at accept: DIV/REM (op[0]=0) work on absolute values.
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && a[XLEN-1]) ? negate(a) : a;
    b_mag     = (signed_op && b[XLEN-1]) ? negate(b) : b;
  end

  // One restoring step: shift the next dividend bit into the remainder and trial-subtract d.
  always_comb begin
    sh   = {r[XLEN-2:0], q[XLEN-1]};
    // r[63] set means the shifted remainder is 65 bits wide, so it always exceeds d.
    qbit = r[XLEN-1] | c_o;
  end

  adder64b u_adder (
    .a   (sh),
    .b   (d),
    .sub (1'b1),
    .s   (diff),
    .c_o (c_o)
  );

  // Sign fix-up of the unsigned core result; DIV by zero must read -1 regardless of dividend sign.
  always_comb begin
    quo = neg_q ? negate(q) : q;
    if (op_q == DIV_OP_DIV && d == '0) begin
      quo = '1;
    end
    rem        = neg_r ? negate(r) : r;
    is_rem     = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);
    fix_result = is_rem ? rem : quo;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= 2'b00;
      q      <= '0;
      d      <= '0;
      r      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= 6'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            q     <= a_mag;
            d     <= b_mag;
            r     <= '0;
            neg_q <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r <= signed_op & a[XLEN-1];
            cnt   <= 6'd63;
            busy  <= 1'b1;
            state <= ST_RUN;
`ifdef DIV_EARLY_OUT_EN
            // Preload what 64 iterations against d=0 would leave: all-ones quotient, dividend as remainder.
            if (b == '0) begin
              q     <= '1;
              r     <= a_mag;
              state <= ST_FIX;
            end
`endif
          end
        end
        ST_RUN: begin
          r <= qbit ? diff : sh;
          q <= {q[XLEN-2:0], qbit};
          if (cnt == 6'd0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        ST_FIX: begin
          result <= fix_result;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
